// File: rtl/blake2s_block_sched.sv
// BLAKE2s block scheduler: buffers message blocks, owns chaining value h and byte counter t,
// issues compression jobs and captures the digest. Optional: BLAKE2_DIGEST_MASK_EN zeroes digest bytes >= nn.
module blake2s_block_sched #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         block_v_i,
  input  logic [511:0] block_i,
  input  logic         block_first_i,
  input  logic         block_last_i,
  input  logic [7:0]   kk_i,
  input  logic [7:0]   nn_i,
  input  logic [7:0]   ll_i,
  output logic         cmp_v_o,
  input  logic         cmp_ready_i,
  output logic [255:0] cmp_h_o,
  output logic [511:0] cmp_m_o,
  output logic [63:0]  cmp_t_o,
  output logic         cmp_f_o,
  input  logic         res_v_i,
  input  logic [255:0] res_h_i,
  output logic         hash_v_o,
  output logic [255:0] hash_o,
  output logic         overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [255:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                 32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  entry_t         fifo_mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, push, pop;
  entry_t         head;

  state_t         state, state_nxt;
  logic           load, capture;

  logic [255:0]   h_q;
  logic [511:0]   m_q;
  logic [63:0]    t_q;
  logic           f_q;
  logic [7:0]     kk_q, nn_q, ll_q;

  // ---------------- FIFO ----------------
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A same-cycle pop frees the slot, so a push while full still lands.
  assign push  = block_v_i && (!full || pop);
  assign head  = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{blk: block_i, first: block_first_i, last: block_last_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (block_v_i && !push) overflow_o <= 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmp_v_o   = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        load      = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        cmp_v_o = 1'b1;
        if (cmp_ready_i) begin
          pop       = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: if (res_v_i) begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- job setup ----------------
  // A first block uses the live config, since it is being latched in the same cycle.
  logic [7:0]   eff_kk, eff_ll;
  logic [6:0]   tail;
  logic [63:0]  t_base, t_nxt;
  logic [255:0] h_init;

  assign eff_kk = head.first ? kk_i : kk_q;
  assign eff_ll = head.first ? ll_i : ll_q;
  assign h_init = IV ^ {224'd0, 32'h01010000 ^ {16'd0, kk_i, 8'd0} ^ {24'd0, nn_i}};
  assign t_base = head.first ? 64'd0 : t_q;
  assign t_nxt  = t_base + (head.last ? {57'd0, tail} : 64'd64);

  always_comb begin
    tail = 7'd0;
    if (eff_ll[5:0] != 6'd0)               tail = {1'b0, eff_ll[5:0]};
    else if (eff_ll != 8'd0 || eff_kk != 8'd0) tail = 7'd64;
  end

  logic [255:0] digest;
  always_comb begin
    digest = res_h_i;
`ifdef BLAKE2_DIGEST_MASK_EN
    for (int i = 0; i < 32; i++)
      if (i >= int'(nn_q)) digest[8*i +: 8] = 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      f_q      <= 1'b0;
      kk_q     <= '0;
      nn_q     <= '0;
      ll_q     <= '0;
      hash_o   <= '0;
      hash_v_o <= 1'b0;
    end else begin
      hash_v_o <= 1'b0;
      if (load) begin
        if (head.first) begin
          h_q  <= h_init;
          kk_q <= kk_i;
          nn_q <= nn_i;
          ll_q <= ll_i;
        end
        t_q <= t_nxt;
        m_q <= head.blk;
        f_q <= head.last;
      end
      if (capture) begin
        h_q <= res_h_i;
        if (f_q) begin
          hash_o   <= digest;
          hash_v_o <= 1'b1;
        end
      end
    end
  end

  assign cmp_h_o = h_q;
  assign cmp_m_o = m_q;
  assign cmp_t_o = t_q;
  assign cmp_f_o = f_q;
endmodule

// File: tb/tb_blake2s_block_sched.sv
// Directed bench for blake2s_block_sched: table of single-block messages plus
// hand-written sequences for chaining, overflow, push/pop while full and reset mid-job.
module tb_blake2s_block_sched;
  localparam logic [255:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                 32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
`ifdef BLAKE2_DIGEST_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         block_v_i, block_first_i, block_last_i;
  logic [511:0] block_i;
  logic [7:0]   kk_i, nn_i, ll_i;
  logic         cmp_v_o, cmp_ready_i, cmp_f_o;
  logic [255:0] cmp_h_o;
  logic [511:0] cmp_m_o;
  logic [63:0]  cmp_t_o;
  logic         res_v_i;
  logic [255:0] res_h_i;
  logic         hash_v_o, overflow_o;
  logic [255:0] hash_o;

  int checks = 0;
  int errors = 0;

  blake2s_block_sched #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .block_v_i(block_v_i), .block_i(block_i), .block_first_i(block_first_i),
    .block_last_i(block_last_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .cmp_v_o(cmp_v_o), .cmp_ready_i(cmp_ready_i), .cmp_h_o(cmp_h_o), .cmp_m_o(cmp_m_o),
    .cmp_t_o(cmp_t_o), .cmp_f_o(cmp_f_o), .res_v_i(res_v_i), .res_h_i(res_h_i),
    .hash_v_o(hash_v_o), .hash_o(hash_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  kk, nn, ll;
    logic [31:0] exp_h0;
    logic [63:0] exp_t;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] blk_of(input int i);
    return {16{32'hC0DE0000 | 32'(i)}};
  endfunction

  function automatic logic [255:0] res_of(input int i);
    return {8{32'h89AB0000 | 32'(i)}};
  endfunction

  function automatic logic [255:0] exp_digest(input logic [255:0] h, input logic [7:0] nn);
    logic [255:0] r = h;
    for (int i = 0; i < 32; i++)
      if (MASK && i >= int'(nn)) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [511:0] b, input logic first, input logic last,
                      input logic [7:0] kk, input logic [7:0] nn, input logic [7:0] ll);
    block_i = b; block_first_i = first; block_last_i = last;
    kk_i = kk; nn_i = nn; ll_i = ll;
    block_v_i = 1'b1;
    @(negedge clk);
    block_v_i = 1'b0;
  endtask

  task automatic wait_job(input string name);
    int n = 0;
    while (!cmp_v_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, cmp_v_o, 1'b1);
  endtask

  task automatic handshake();
    cmp_ready_i = 1'b1;
    @(negedge clk);
    cmp_ready_i = 1'b0;
  endtask

  task automatic send_result(input string name, input logic [255:0] h, input logic fire,
                             input logic [255:0] exp_hash);
    res_v_i = 1'b1; res_h_i = h;
    @(negedge clk);
    res_v_i = 1'b0;
    check({name, "_hash_v"}, hash_v_o, fire);
    if (fire) check({name, "_hash"}, hash_o, exp_hash);
    @(negedge clk);
    check({name, "_hash_v_clr"}, hash_v_o, 1'b0);
  endtask

  initial begin
    vecs[0] = '{kk: 8'd0,  nn: 8'd32, ll: 8'd3,   exp_h0: 32'h6B08E647, exp_t: 64'd3};
    vecs[1] = '{kk: 8'd32, nn: 8'd16, ll: 8'd0,   exp_h0: 32'h6B08C677, exp_t: 64'd64};
    vecs[2] = '{kk: 8'd0,  nn: 8'd32, ll: 8'd0,   exp_h0: 32'h6B08E647, exp_t: 64'd0};
    vecs[3] = '{kk: 8'd0,  nn: 8'd32, ll: 8'd64,  exp_h0: 32'h6B08E647, exp_t: 64'd64};
    vecs[4] = '{kk: 8'd0,  nn: 8'd1,  ll: 8'd5,   exp_h0: 32'h6B08E666, exp_t: 64'd5};
    vecs[5] = '{kk: 8'd0,  nn: 8'd20, ll: 8'd10,  exp_h0: 32'h6B08E673, exp_t: 64'd10};
    vecs[6] = '{kk: 8'd16, nn: 8'd32, ll: 8'd0,   exp_h0: 32'h6B08F647, exp_t: 64'd64};
    vecs[7] = '{kk: 8'd0,  nn: 8'd32, ll: 8'd255, exp_h0: 32'h6B08E647, exp_t: 64'd63};

    reset = 1'b1; block_v_i = 0; block_i = '0; block_first_i = 0; block_last_i = 0;
    kk_i = 0; nn_i = 0; ll_i = 0; cmp_ready_i = 0; res_v_i = 0; res_h_i = '0;
    repeat (3) @(negedge clk);
    check("rst_cmp_v", cmp_v_o, 1'b0);
    check("rst_hash_v", hash_v_o, 1'b0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_hash", hash_o, 256'd0);
    check("rst_h", cmp_h_o, 256'd0);
    check("rst_t", cmp_t_o, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // single-block messages
    for (int i = 0; i < 8; i++) begin
      push(blk_of(i), 1'b1, 1'b1, vecs[i].kk, vecs[i].nn, vecs[i].ll);
      check($sformatf("v%0d_lat1", i), cmp_v_o, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_lat2", i), cmp_v_o, 1'b1);
      check($sformatf("v%0d_h", i), cmp_h_o, {IV[255:32], vecs[i].exp_h0});
      check($sformatf("v%0d_t", i), cmp_t_o, vecs[i].exp_t);
      check($sformatf("v%0d_f", i), cmp_f_o, 1'b1);
      check($sformatf("v%0d_m", i), cmp_m_o, blk_of(i));
      handshake();
      check($sformatf("v%0d_busy", i), cmp_v_o, 1'b0);
      send_result($sformatf("v%0d", i), res_of(i), 1'b1, exp_digest(res_of(i), vecs[i].nn));
    end

    // two-block message, ll=100
    reset_dut();
    push(blk_of(20), 1'b1, 1'b0, 8'd0, 8'd32, 8'd100);
    push(blk_of(21), 1'b0, 1'b1, 8'd0, 8'd32, 8'd100);
    wait_job("two_j1");
    check("two_j1_h", cmp_h_o, {IV[255:32], 32'h6B08E647});
    check("two_j1_t", cmp_t_o, 64'd64);
    check("two_j1_f", cmp_f_o, 1'b0);
    check("two_j1_m", cmp_m_o, blk_of(20));
    handshake();
    send_result("two_j1", res_of(20), 1'b0, '0);
    wait_job("two_j2");
    check("two_j2_h", cmp_h_o, res_of(20));
    check("two_j2_t", cmp_t_o, 64'd100);
    check("two_j2_f", cmp_f_o, 1'b1);
    check("two_j2_m", cmp_m_o, blk_of(21));
    handshake();
    send_result("two_j2", res_of(21), 1'b1, exp_digest(res_of(21), 8'd32));

    // overflow: three pushes while the core stalls
    reset_dut();
    push(blk_of(30), 1'b1, 1'b1, 8'd0, 8'd32, 8'd3);
    push(blk_of(31), 1'b1, 1'b1, 8'd0, 8'd32, 8'd3);
    check("ovf_before", overflow_o, 1'b0);
    push(blk_of(32), 1'b1, 1'b1, 8'd0, 8'd32, 8'd3);
    check("ovf_set", overflow_o, 1'b1);
    check("ovf_j1_m", cmp_m_o, blk_of(30));
    handshake();
    send_result("ovf_j1", res_of(30), 1'b1, exp_digest(res_of(30), 8'd32));
    wait_job("ovf_j2");
    check("ovf_j2_m", cmp_m_o, blk_of(31));
    handshake();
    send_result("ovf_j2", res_of(31), 1'b1, exp_digest(res_of(31), 8'd32));
    begin
      logic extra = 1'b0;
      repeat (6) begin
        @(negedge clk);
        extra |= cmp_v_o;
      end
      check("ovf_no_j3", extra, 1'b0);
    end
    check("ovf_sticky", overflow_o, 1'b1);

    // push while full coinciding with the pop is accepted
    reset_dut();
    push(blk_of(40), 1'b1, 1'b1, 8'd0, 8'd32, 8'd3);
    push(blk_of(41), 1'b1, 1'b1, 8'd0, 8'd32, 8'd3);
    check("pp_issue", cmp_v_o, 1'b1);
    cmp_ready_i = 1'b1;
    block_i = blk_of(42); block_v_i = 1'b1;
    @(negedge clk);
    cmp_ready_i = 1'b0; block_v_i = 1'b0;
    check("pp_no_ovf", overflow_o, 1'b0);
    send_result("pp_j1", res_of(40), 1'b1, exp_digest(res_of(40), 8'd32));
    wait_job("pp_j2");
    check("pp_j2_m", cmp_m_o, blk_of(41));
    handshake();
    send_result("pp_j2", res_of(41), 1'b1, exp_digest(res_of(41), 8'd32));
    wait_job("pp_j3");
    check("pp_j3_m", cmp_m_o, blk_of(42));
    handshake();
    send_result("pp_j3", res_of(42), 1'b1, exp_digest(res_of(42), 8'd32));

    // reset while BUSY abandons the job; a late result is ignored
    reset_dut();
    push(blk_of(50), 1'b1, 1'b1, 8'd0, 8'd32, 8'd3);
    wait_job("rb");
    handshake();
    reset_dut();
    res_v_i = 1'b1; res_h_i = res_of(50);
    @(negedge clk);
    res_v_i = 1'b0;
    check("rb_hash_v", hash_v_o, 1'b0);
    check("rb_hash", hash_o, 256'd0);
    check("rb_h", cmp_h_o, 256'd0);
    begin
      logic any_v = 1'b0;
      repeat (5) begin
        @(negedge clk);
        any_v |= cmp_v_o | hash_v_o;
      end
      check("rb_idle", any_v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
